// File: rtl/reg_file_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : reg_file_pkg
//  Purpose  : Shared constants, state encoding and byte-mask helper for the
//             bypassing register file and its clear controller.
//  Revision : 1.0  initial release
// ============================================================================
package reg_file_pkg;

  localparam int REG_WIDTH  = 32;
  localparam int REG_ADDR_W = 5;

  // State encoding; IDLE is reserved and never entered on purpose.
  localparam int STATE_W = 2;
  typedef logic [STATE_W-1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_CLEAR = 2'd1;
  localparam state_t ST_RUN   = 2'd2;

  // Expands one byte-enable bit into the 8-bit slice of the merge mask.
  function automatic logic [7:0] be_byte_mask(input logic be);
    return {8{be}};
  endfunction

endpackage
`default_nettype wire

// File: rtl/reg_file_clear_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : reg_file_clear_ctrl
//  Purpose  : Sequences the post-reset clear of the register file, one entry
//             per cycle, and reports when the file is not usable.
//  Revision : 1.0  initial release
// ============================================================================
module reg_file_clear_ctrl
  import reg_file_pkg::*;
#(
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  output logic              o_busy,
  output logic              o_clr_we,
  output logic [ADDR_W-1:0] o_clr_addr
);

  localparam logic [ADDR_W-1:0] C_LAST_IDX = ADDR_W'(DEPTH - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_clr_idx;

  // State register and clear index; reset always restarts the walk at entry 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_CLEAR;
      r_clr_idx <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_CLEAR) begin
        r_clr_idx <= r_clr_idx + 1'b1;
      end
    end
  end

  // Next state: leave CLEAR once the last entry has been zeroed.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  w_state_nxt = ST_CLEAR;
      ST_CLEAR: if (r_clr_idx == C_LAST_IDX) w_state_nxt = ST_RUN;
      ST_RUN:   w_state_nxt = ST_RUN;
      default:  w_state_nxt = ST_CLEAR;
    endcase
  end

  // Outputs: busy outside RUN; clear strobe only while the walk advances.
  always_comb begin
    o_busy     = (r_state != ST_RUN);
    o_clr_we   = (r_state == ST_CLEAR) && !rst;
    o_clr_addr = r_clr_idx;
  end

endmodule
`default_nettype wire

// File: rtl/reg_file_bp.sv
`default_nettype none
// ============================================================================
//  Module   : reg_file_bp
//  Purpose  : Register file with one byte-enabled write port, two
//             combinational read ports, optional write-to-read bypass and
//             optional hardwired-zero entry 0. Cleared by hardware after reset.
//  Revision : 1.0  initial release
// ============================================================================
module reg_file_bp
  import reg_file_pkg::*;
#(
  parameter int WIDTH    = REG_WIDTH,
  parameter int ADDR_W   = REG_ADDR_W,
  parameter int DEPTH    = 2**ADDR_W,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [WIDTH/8-1:0] w_be,
  input  logic [ADDR_W-1:0]  w_addr,
  input  logic [WIDTH-1:0]   d_in,
  input  logic [ADDR_W-1:0]  r_addr_a,
  output logic [WIDTH-1:0]   d_out_a,
  input  logic [ADDR_W-1:0]  r_addr_b,
  output logic [WIDTH-1:0]   d_out_b,
  output logic               busy
);

  localparam int NBYTES = WIDTH / 8;
  // Index width actually needed to address DEPTH entries.
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0]  r_mem [DEPTH];

  logic              w_clr_we;
  logic [ADDR_W-1:0] w_clr_addr;
  logic              w_wr_ok;
  logic [IDX_W-1:0]  w_widx;
  logic [WIDTH-1:0]  w_mask;
  logic [WIDTH-1:0]  w_stored;
  logic [WIDTH-1:0]  w_merged;
  logic [ADDR_W-1:0] w_raddr [2];
  logic [WIDTH-1:0]  w_rdata [2];

  reg_file_clear_ctrl #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_clear_ctrl (
    .clk        (clk),
    .rst        (rst),
    .o_busy     (busy),
    .o_clr_we   (w_clr_we),
    .o_clr_addr (w_clr_addr)
  );

  for (genvar i = 0; i < NBYTES; i++) begin : g_mask
    assign w_mask[8*i +: 8] = be_byte_mask(w_be[i]);
  end

  // A user write qualifies only in RUN, in range, and not to a hardwired zero.
  assign w_wr_ok  = !busy && we && (int'(w_addr) < DEPTH) &&
                    !((ZERO_REG != 0) && (w_addr == '0));
  assign w_widx   = w_addr[IDX_W-1:0];
  assign w_stored = r_mem[w_widx];
  assign w_merged = (d_in & w_mask) | (w_stored & ~w_mask);

  // Storage update: the clear walk has priority, user writes are dropped meanwhile.
  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[w_clr_addr[IDX_W-1:0]] <= '0;
    end else if (w_wr_ok) begin
      r_mem[w_widx] <= w_merged;
    end
  end

  assign w_raddr[0] = r_addr_a;
  assign w_raddr[1] = r_addr_b;
  assign d_out_a    = w_rdata[0];
  assign d_out_b    = w_rdata[1];

  for (genvar p = 0; p < 2; p++) begin : g_rd_port
    logic [IDX_W-1:0] w_ridx;
    assign w_ridx = w_raddr[p][IDX_W-1:0];

    // Combinational read with zero/out-of-range masking and optional bypass.
    always_comb begin
      w_rdata[p] = r_mem[w_ridx];
      if (busy) begin
        w_rdata[p] = '0;
      end else if ((ZERO_REG != 0) && (w_raddr[p] == '0)) begin
        w_rdata[p] = '0;
      end else if (int'(w_raddr[p]) >= DEPTH) begin
        w_rdata[p] = '0;
      end else if ((BYPASS != 0) && w_wr_ok && (w_raddr[p] == w_addr)) begin
        w_rdata[p] = w_merged;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_reg_file_bp.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reg_file_bp
//  Purpose  : Directed self-checking bench for reg_file_bp, covering the
//             default configuration plus no-bypass, no-zero-reg and
//             reduced-depth variants driven from shared stimulus.
//  Revision : 1.0  initial release
// ============================================================================
module tb_reg_file_bp;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we = 1'b0;
  logic [3:0]  w_be = 4'h0;
  logic [4:0]  w_addr = 5'd0;
  logic [31:0] d_in = 32'h0;
  logic [4:0]  r_addr_a = 5'd0;
  logic [4:0]  r_addr_b = 5'd0;

  logic [31:0] a_out_a, a_out_b, nb_out_a, nb_out_b;
  logic [31:0] nz_out_a, nz_out_b, d20_out_a, d20_out_b;
  logic        a_busy, nb_busy, nz_busy, d20_busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  reg_file_bp dut (
    .clk(clk), .rst(rst), .we(we), .w_be(w_be), .w_addr(w_addr), .d_in(d_in),
    .r_addr_a(r_addr_a), .d_out_a(a_out_a), .r_addr_b(r_addr_b), .d_out_b(a_out_b),
    .busy(a_busy)
  );

  reg_file_bp #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .we(we), .w_be(w_be), .w_addr(w_addr), .d_in(d_in),
    .r_addr_a(r_addr_a), .d_out_a(nb_out_a), .r_addr_b(r_addr_b), .d_out_b(nb_out_b),
    .busy(nb_busy)
  );

  reg_file_bp #(.ZERO_REG(0)) dut_nz (
    .clk(clk), .rst(rst), .we(we), .w_be(w_be), .w_addr(w_addr), .d_in(d_in),
    .r_addr_a(r_addr_a), .d_out_a(nz_out_a), .r_addr_b(r_addr_b), .d_out_b(nz_out_b),
    .busy(nz_busy)
  );

  reg_file_bp #(.DEPTH(20)) dut_d20 (
    .clk(clk), .rst(rst), .we(we), .w_be(w_be), .w_addr(w_addr), .d_in(d_in),
    .r_addr_a(r_addr_a), .d_out_a(d20_out_a), .r_addr_b(r_addr_b), .d_out_b(d20_out_b),
    .busy(d20_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] be);
    we = 1'b1; w_addr = addr; d_in = data; w_be = be;
    tick();
    we = 1'b0;
  endtask

  task automatic test_reset();
    int k;
    int cnt_a;
    int cnt_d;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    k = 0;
    while ((a_busy || d20_busy) && k < 200) begin tick(); k++; end
    n_checks++;
    if (a_busy !== 1'b0) begin n_fail++; $display("FAIL init_busy got %b want 0", a_busy); end
    // Preload every entry with all ones so the clear is observable.
    for (int a = 0; a < 32; a++) wr(5'(a), 32'hFFFF_FFFF, 4'hF);
    r_addr_a = 5'd5; r_addr_b = 5'd9;
    #1;
    n_checks++;
    if (a_out_a !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL preload got %h want ffffffff", a_out_a); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cnt_a = 0; cnt_d = 0;
    for (int i = 0; i < 100 && (a_busy || d20_busy); i++) begin
      if (i == 0) begin
        n_checks++;
        if (a_out_a !== 32'h0 || a_out_b !== 32'h0) begin
          n_fail++; $display("FAIL clear_reads_zero got %h/%h want 0", a_out_a, a_out_b);
        end
      end
      if (a_busy) cnt_a++;
      if (d20_busy) cnt_d++;
      tick();
    end
    n_checks++;
    if (cnt_a != 32) begin n_fail++; $display("FAIL busy_len got %0d want 32", cnt_a); end
    n_checks++;
    if (cnt_d != 20) begin n_fail++; $display("FAIL busy_len_d20 got %0d want 20", cnt_d); end
    for (int a = 0; a < 32; a++) begin
      r_addr_a = 5'(a); r_addr_b = 5'(a);
      #1;
      n_checks++;
      if (a_out_a !== 32'h0 || a_out_b !== 32'h0 || nb_out_a !== 32'h0 ||
          nz_out_a !== 32'h0 || d20_out_a !== 32'h0) begin
        n_fail++;
        $display("FAIL cleared[%0d] got %h %h %h %h %h want 0", a, a_out_a, a_out_b,
                 nb_out_a, nz_out_a, d20_out_a);
      end
    end
  endtask

  task automatic test_out_of_range();
    wr(5'd25, 32'hCAFE_F00D, 4'hF);
    r_addr_a = 5'd25;
    #1;
    n_checks++;
    if (d20_out_a !== 32'h0) begin n_fail++; $display("FAIL oor_read got %h want 0", d20_out_a); end
    n_checks++;
    if (a_out_a !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL full_depth_25 got %h want cafef00d", a_out_a); end
    for (int a = 0; a < 20; a++) begin
      r_addr_b = 5'(a);
      #1;
      n_checks++;
      if (d20_out_b !== 32'h0) begin n_fail++; $display("FAIL oor_no_change[%0d] got %h want 0", a, d20_out_b); end
    end
    we = 1'b1; w_addr = 5'd25; d_in = 32'h1212_1212; w_be = 4'hF; r_addr_b = 5'd25;
    #1;
    n_checks++;
    if (d20_out_b !== 32'h0) begin n_fail++; $display("FAIL oor_bypass got %h want 0", d20_out_b); end
    n_checks++;
    if (a_out_b !== 32'h1212_1212) begin n_fail++; $display("FAIL bypass_25 got %h want 12121212", a_out_b); end
    tick();
    we = 1'b0;
  endtask

  task automatic test_byte_enable();
    wr(5'd5, 32'hDEAD_BEEF, 4'b1111);
    wr(5'd5, 32'h0000_00AA, 4'b0001);
    r_addr_a = 5'd5;
    #1;
    n_checks++;
    if (a_out_a !== 32'hDEAD_BEAA) begin n_fail++; $display("FAIL be_low got %h want deadbeaa", a_out_a); end
    n_checks++;
    if (nb_out_a !== 32'hDEAD_BEAA) begin n_fail++; $display("FAIL be_low_nb got %h want deadbeaa", nb_out_a); end
    wr(5'd5, 32'h1122_3344, 4'b0110);
    #1;
    n_checks++;
    if (a_out_a !== 32'hDE22_33AA) begin n_fail++; $display("FAIL be_mid got %h want de2233aa", a_out_a); end
  endtask

  task automatic test_bypass();
    wr(5'd7, 32'h0000_FFFF, 4'hF);
    we = 1'b1; w_addr = 5'd7; d_in = 32'h1234_5678; w_be = 4'b1100;
    r_addr_a = 5'd7; r_addr_b = 5'd7;
    #1;
    n_checks++;
    if (a_out_a !== 32'h1234_FFFF || a_out_b !== 32'h1234_FFFF) begin
      n_fail++; $display("FAIL bypass_both got %h/%h want 1234ffff", a_out_a, a_out_b);
    end
    n_checks++;
    if (nb_out_a !== 32'h0000_FFFF || nb_out_b !== 32'h0000_FFFF) begin
      n_fail++; $display("FAIL nobypass_same got %h/%h want 0000ffff", nb_out_a, nb_out_b);
    end
    tick();
    we = 1'b0;
    #1;
    n_checks++;
    if (nb_out_a !== 32'h1234_FFFF) begin n_fail++; $display("FAIL nobypass_next got %h want 1234ffff", nb_out_a); end
    n_checks++;
    if (a_out_b !== 32'h1234_FFFF) begin n_fail++; $display("FAIL bypass_stored got %h want 1234ffff", a_out_b); end
    we = 1'b1; w_addr = 5'd7; d_in = 32'h0; w_be = 4'b0000;
    #1;
    n_checks++;
    if (a_out_a !== 32'h1234_FFFF) begin n_fail++; $display("FAIL be_zero_bypass got %h want 1234ffff", a_out_a); end
    tick();
    we = 1'b0;
    #1;
    n_checks++;
    if (a_out_a !== 32'h1234_FFFF) begin n_fail++; $display("FAIL be_zero_kept got %h want 1234ffff", a_out_a); end
  endtask

  task automatic test_zero_reg();
    wr(5'd0, 32'hFFFF_FFFF, 4'hF);
    r_addr_a = 5'd0; r_addr_b = 5'd0;
    #1;
    n_checks++;
    if (a_out_a !== 32'h0) begin n_fail++; $display("FAIL zero_reg got %h want 0", a_out_a); end
    n_checks++;
    if (nz_out_a !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL nozero_reg got %h want ffffffff", nz_out_a); end
    we = 1'b1; w_addr = 5'd0; d_in = 32'h1111_1111; w_be = 4'hF;
    #1;
    n_checks++;
    if (a_out_a !== 32'h0 || a_out_b !== 32'h0) begin
      n_fail++; $display("FAIL zero_bypass got %h/%h want 0", a_out_a, a_out_b);
    end
    n_checks++;
    if (nz_out_b !== 32'h1111_1111) begin n_fail++; $display("FAIL nozero_bypass got %h want 11111111", nz_out_b); end
    tick();
    we = 1'b0;
  endtask

  task automatic test_reset_mid_clear();
    int cnt_a;
    int cnt_d;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    we = 1'b1; w_be = 4'hF; d_in = 32'hA5A5_A5A5;
    for (int i = 0; i < 10; i++) begin w_addr = 5'(i); tick(); end
    n_checks++;
    if (a_busy !== 1'b1) begin n_fail++; $display("FAIL mid_clear_busy got %b want 1", a_busy); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    w_addr = 5'd3;
    cnt_a = 0; cnt_d = 0;
    for (int i = 0; i < 100 && (a_busy || d20_busy); i++) begin
      if (a_busy) begin cnt_a++; w_addr = 5'(i); end
      if (d20_busy) cnt_d++;
      tick();
    end
    we = 1'b0;
    n_checks++;
    if (cnt_a != 32) begin n_fail++; $display("FAIL restart_busy_len got %0d want 32", cnt_a); end
    n_checks++;
    if (cnt_d != 20) begin n_fail++; $display("FAIL restart_busy_len_d20 got %0d want 20", cnt_d); end
    for (int a = 0; a < 32; a++) begin
      r_addr_a = 5'(a); r_addr_b = 5'(a);
      #1;
      n_checks++;
      if (a_out_a !== 32'h0 || a_out_b !== 32'h0 || nb_out_a !== 32'h0 || nz_out_a !== 32'h0) begin
        n_fail++;
        $display("FAIL restart_cleared[%0d] got %h %h %h %h want 0", a, a_out_a, a_out_b,
                 nb_out_a, nz_out_a);
      end
    end
  endtask

  initial begin
    test_reset();
    test_out_of_range();
    test_byte_enable();
    test_bypass();
    test_zero_reg();
    test_reset_mid_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/reg_file_bp.md
Name: reg_file_bp

Overview:
- Parametrised register file for the MIPS core: one write port with byte enables, two asynchronous read ports, optional write-to-read bypass, optional hardwired-zero register 0.
- Replaces file-loaded initial contents with a hardware clear sequence: reset walks every entry to zero, one entry per cycle.
- Sits between the decode stage (read addresses) and the writeback stage (write port).
- A busy flag tells the pipeline when the file is not usable.

Parameters:
- WIDTH, 32, data width in bits; must be a multiple of 8.
- ADDR_W, 5, address width.
- DEPTH, 2**ADDR_W, number of entries; must be <= 2**ADDR_W.
- ZERO_REG, 1, when 1 entry 0 always reads 0 and ignores writes.
- BYPASS, 1, when 1 a same-cycle write to the addressed entry is forwarded to the read port.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- we  in  1  write enable.
- w_be  in  WIDTH/8  byte enables; bit i covers d_in[8i+7:8i].
- w_addr  in  ADDR_W  write address.
- d_in  in  WIDTH  write data.
- r_addr_a  in  ADDR_W  read address, port A.
- d_out_a  out  WIDTH  read data, port A.
- r_addr_b  in  ADDR_W  read address, port B.
- d_out_b  out  WIDTH  read data, port B.
- busy  out  1  high while the clear sequence runs.

Behaviour:
- States:
  - CLEAR: a counter clr_idx writes 0 to entry clr_idx each cycle.
  - RUN: normal operation.
- rst=1 at an edge: next state CLEAR, clr_idx=0. This holds from any state, including mid-clear, where the sequence restarts at 0.
- CLEAR, rst=0: entry clr_idx <= 0; clr_idx increments.
  - When clr_idx==DEPTH-1, next state is RUN.
  - Clear lasts exactly DEPTH cycles after rst deasserts.
- Reset values:
  - busy=1 from the edge where rst is sampled high until the edge that enters RUN.
  - d_out_a and d_out_b read 0 throughout CLEAR.
- CLEAR: we is ignored and user writes are dropped.
- RUN, write: we=1 and w_addr<DEPTH and not (ZERO_REG and w_addr==0). At the edge, byte i of entry w_addr takes d_in byte i where w_be[i]=1; other bytes are kept.
- we=1 with w_be=0 leaves the entry unchanged.
- w_addr>=DEPTH: the write is ignored.
- Reads are combinational, with zero latency.
  - If ZERO_REG and addr==0, output 0.
  - addr>=DEPTH outputs 0.
  - Otherwise output the stored entry.
- BYPASS=1, RUN, read addr==w_addr, and the write qualifies per the rules above: output the merged word in the same cycle. Merged word = d_in bytes where w_be=1, stored bytes elsewhere.
- BYPASS=0: reads return the pre-edge contents, so a write becomes visible the cycle after the edge.
- Both read ports may address the same entry, with identical results. Both may also hit the bypass at once.
- No X on outputs after the first reset.
- Contents before the first reset are undefined.

Decomposition:
- Shared package reg_file_pkg holds:
  - default constants REG_WIDTH=32, REG_ADDR_W=5;
  - state encoding for IDLE/CLEAR/RUN, where IDLE is unused and reserved;
  - a function that builds the byte-enable merge mask.
- One sub-module, reg_file_clear_ctrl, holds the state register, clr_idx counter, busy, and the clear write strobe/address.
- Storage array, write mux and read/bypass logic stay in reg_file_bp.

Test Plan:
- Reset, then rst=1 for 1 cycle -> busy=1 for exactly 32 cycles. Then read of every address = 0, including entries preloaded with 0xFFFFFFFF before reset.
- RUN: write 0xDEADBEEF to r5 with w_be=4'b1111, then write 0x000000AA to r5 with w_be=4'b0001 -> next-cycle read r5 = 0xDEADBEAA.
- BYPASS=1: we=1, w_addr=7, d_in=0x12345678, w_be=4'b1100, r7 stored 0x0000FFFF; r_addr_a=r_addr_b=7 in the same cycle -> both outputs 0x1234FFFF combinationally. BYPASS=0 -> 0x0000FFFF that cycle, 0x1234FFFF the next.
- ZERO_REG=1: write 0xFFFFFFFF to r0 -> r0 reads 0, bypass does not forward. ZERO_REG=0 -> r0 reads 0xFFFFFFFF.
- rst asserted at clear cycle 10, with writes issued during CLEAR -> restarts, busy lasts 32 cycles from the new deassertion, and all entries read 0.
- DEPTH=20, ADDR_W=5: write to addr 25 -> no entry changes, read addr 25 = 0, clear lasts 20 cycles.
